// File: rtl/spi_ram_ctrl_if.sv
// Core-side request/response bus of the SPI SRAM controller.
// The core is the master and drives the request; the controller answers with busy/ack/rdata.
interface spi_ram_ctrl_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        busy;
   logic        ack;
   logic [15:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  busy, ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output busy, ack, rdata
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// One 16-bit word per request to a 23LC512-class SPI SRAM (sequential mode, SPI mode 0).
// Frame: opcode, 16-bit address, two data bytes, all MSB first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | CS high, waiting for req
//   ST_SHIFT | CS low, 40 bits clocked out (and MISO sampled on SCK rise)
//   ST_DONE  | CS high, ack pulse, read word visible on rdata
module spi_ram_ctrl #(
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02,
   parameter int unsigned SCK_DIV   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_ram_ctrl_if.slave  bus,
   output logic           spi_cs_n,
   output logic           spi_sck,
   output logic           spi_mosi,
   input  logic           spi_miso
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [2:0] DIV_LOAD = 3'(SCK_DIV - 1);
   localparam logic [5:0] LAST_BIT = 6'd39;

   state_t      state;
   logic [2:0]  div_cnt;
   logic [5:0]  bit_cnt;
   logic [38:0] tx_sr;
   logic [15:0] rx_sr;
   logic        rd_op;
   logic        busy_q;
   logic        ack_q;
   logic [15:0] rdata_q;
   logic [7:0]  opcode;

   assign opcode    = bus.we ? CMD_WRITE : CMD_READ;
   assign bus.busy  = busy_q;
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rd_op    <= 1'b0;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         spi_cs_n <= 1'b1;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  state    <= ST_SHIFT;
                  rd_op    <= !bus.we;
                  // first bit goes straight to MOSI, the remaining 39 wait in tx_sr
                  tx_sr    <= {opcode[6:0], bus.addr, (bus.we ? bus.wdata : 16'h0000)};
                  spi_mosi <= opcode[7];
                  spi_cs_n <= 1'b0;
                  spi_sck  <= 1'b0;
                  busy_q   <= 1'b1;
                  div_cnt  <= DIV_LOAD;
                  bit_cnt  <= LAST_BIT;
               end
            end

            ST_SHIFT: begin
               if (div_cnt != 3'd0) begin
                  div_cnt <= div_cnt - 3'd1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!spi_sck) begin
                     spi_sck <= 1'b1;
                     rx_sr   <= {rx_sr[14:0], spi_miso};
                  end else begin
                     spi_sck <= 1'b0;
                     if (bit_cnt == 6'd0) begin
                        state    <= ST_DONE;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        ack_q    <= 1'b1;
                        if (rd_op) begin
                           rdata_q <= rx_sr;
                        end
                     end else begin
                        bit_cnt  <= bit_cnt - 6'd1;
                        spi_mosi <= tx_sr[38];
                        tx_sr    <= {tx_sr[37:0], 1'b0};
                     end
                  end
               end
            end

            ST_DONE: begin
               state  <= ST_IDLE;
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
